// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter
//   Shares one single-port memory between instruction fetch (if_*) and
//   load/store (d_*). Only one access is in flight at a time. Data wins
//   arbitration unless fetch has already lost STARVE_MAX grants in a row.
//   A watchdog ends an access that has gone TIMEOUT cycles with no ack.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   if_req/if_addr/if_gnt      fetch request, address, combinational grant
//   if_rvalid/if_rdata         one-cycle fetch response pulse and data
//   d_req/d_we/d_addr/d_wdata  data request (we=1 store), address, write data
//   d_gnt                      combinational data grant
//   d_rvalid/d_rdata           one-cycle load/store completion pulse, load data
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_ack/mem_rdata          memory completion and read data (same cycle)
//   busy                       access in flight (state != IDLE)
//   timeout_err                one-cycle pulse when the watchdog expires
module rv32_mem_arbiter #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                STARVE_MAX = 4,
  parameter int                TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] FETCH_NOP  = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout_err
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   starve_cnt;
  logic [WW-1:0]   wdog;
  logic            starve_hit;
  logic            expire;

  // Fetch has been passed over STARVE_MAX times and is still waiting.
  assign starve_hit = if_req && (starve_cnt == SW'(STARVE_MAX));

  // wdog counts completed no-ack cycles; the TIMEOUT-th such cycle expires.
  // An ack in that same cycle takes precedence.
  assign expire = busy && !mem_ack && (wdog == WW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_gnt)       state_d = WAIT_D;
        else if (if_gnt) state_d = WAIT_IF;
      end
      WAIT_IF, WAIT_D: if (mem_ack || expire) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    d_gnt  = 1'b0;
    if_gnt = 1'b0;
    if (state_q == IDLE) begin
      if (d_req && !starve_hit) d_gnt  = 1'b1;
      else if (if_req)          if_gnt = 1'b1;
    end
    busy = (state_q != IDLE);
  end

  // Memory command, responses, starvation and watchdog counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rvalid   <= 1'b0;
      if_rdata    <= '0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      timeout_err <= 1'b0;
      starve_cnt  <= '0;
      wdog        <= '0;
    end else begin
      if_rvalid   <= 1'b0;
      d_rvalid    <= 1'b0;
      timeout_err <= 1'b0;
      if (d_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        wdog      <= '0;
        // Count only grants that actually passed over a waiting fetch.
        if (!if_req)                            starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end else if (if_gnt) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        wdog       <= '0;
        starve_cnt <= '0;
      end else if (busy) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (state_q == WAIT_IF) begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end else begin
            if (!mem_we) d_rdata <= mem_rdata;
            d_rvalid <= 1'b1;
          end
        end else if (expire) begin
          mem_req     <= 1'b0;
          timeout_err <= 1'b1;
          if (state_q == WAIT_IF) begin
            if_rdata  <= FETCH_NOP;
            if_rvalid <= 1'b1;
          end else begin
            d_rdata  <= '0;
            d_rvalid <= 1'b1;
          end
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter (STARVE_MAX=4, TIMEOUT=8). A behavioural
// memory answers mem_req after lat_cfg cycles (0 = never). Expected
// responses are queued at grant time and compared when rvalid pulses.
module tb_rv32_mem_arbiter;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, timeout_err;

  rv32_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8),
                     .FETCH_NOP(32'h00000013)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err));

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_data;
    bit          chk_data;
    bit          exp_to;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          chk_data;
    bit          to;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  int          lat_cfg = 0;
  int          mcnt = 0;
  bit          spurious = 0;
  logic [31:0] ram [logic [31:0]];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Memory model: ack in the lat_cfg-th cycle of mem_req; stores update ram.
  initial begin
    mem_ack = 0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (mem_req) mcnt++; else mcnt = 0;
      mem_ack   = spurious || (mem_req && lat_cfg != 0 && mcnt == lat_cfg);
      mem_rdata = (mem_ack && ram.exists(mem_addr)) ? ram[mem_addr] : 32'h0;
      if (spurious) mem_rdata = 32'hBAD0BAD0;
      if (mem_ack && mem_req && mem_we) ram[mem_addr] = mem_wdata;
    end
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (rst_n && (if_rvalid || d_rvalid)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rvalid if_rvalid=%0b d_rvalid=%0b", if_rvalid, d_rvalid);
      end else begin
        me = sb.pop_front();
        chk("rvalid_owner", {30'b0, d_rvalid, if_rvalid}, me.is_d ? 32'd2 : 32'd1);
        if (me.chk_data) chk("rdata", me.is_d ? d_rdata : if_rdata, me.data);
        chk("timeout_err", {31'b0, timeout_err}, {31'b0, me.to});
      end
    end
  end

  task automatic push_exp(input bit is_d, input logic [31:0] data, input bit cd, input bit to);
    exp_t e;
    e.is_d = is_d; e.data = data; e.chk_data = cd; e.to = to;
    sb.push_back(e);
  endtask

  // Called just after a negedge with the request already driven.
  task automatic wait_gnt(input bit is_d, input string nm, output bit got);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (is_d ? d_gnt : if_gnt) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_gnt got none expected grant within 20 cycles", nm);
    end
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_rvalid got no response expected one within 40 cycles", nm);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_txn(input vec_t v, input string nm);
    bit got;
    @(negedge clk);
    lat_cfg = v.lat;
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    wait_gnt(v.is_d, nm, got);
    if (got) push_exp(v.is_d, v.exp_data, v.chk_data, v.exp_to);
    @(posedge clk);
    #1;
    if_req = 0;
    d_req = 0;
    wait_drain(nm);
  endtask

  vec_t vecs[9];
  bit   exp_is_d[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    bit got;
    int n, cnt, rv;
    rst_n = 0;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    ram[32'h100] = 32'h00500093;
    ram[32'h108] = 32'h00A00113;
    ram[32'h040] = 32'h00000055;
    ram[32'h300] = 32'h000000A0;
    ram[32'h500] = 32'h000000B0;

    //        is_d we addr          wdata         lat exp_data      chk to
    vecs[0] = '{0, 0, 32'h108,  32'h0,        1, 32'h00A00113, 1, 0};
    vecs[1] = '{1, 1, 32'h2000, 32'hDEADBEEF, 1, 32'h0,        0, 0};
    vecs[2] = '{1, 0, 32'h2000, 32'h0,        2, 32'hDEADBEEF, 1, 0};
    vecs[3] = '{1, 0, 32'h040,  32'h0,        8, 32'h00000055, 1, 0};
    vecs[4] = '{1, 0, 32'h3000, 32'h0,        0, 32'h0,        1, 1};
    vecs[5] = '{1, 1, 32'h044,  32'h12345678, 3, 32'h0,        0, 0};
    vecs[6] = '{1, 0, 32'h044,  32'h0,        1, 32'h12345678, 1, 0};
    vecs[7] = '{0, 0, 32'h10C,  32'h0,        0, 32'h00000013, 1, 1};
    vecs[8] = '{0, 0, 32'h044,  32'h0,        5, 32'h12345678, 1, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_rdata", if_rdata | d_rdata | mem_addr, 0);
    rst_n = 1;
    @(negedge clk);

    // Single fetch: cycle-by-cycle timing
    lat_cfg = 3;
    if_req = 1; if_addr = 32'h100;
    #1;
    chk("sf_gnt_c0", {31'b0, if_gnt}, 1);
    chk("sf_busy_c0", {31'b0, busy}, 0);
    push_exp(0, 32'h00500093, 1, 0);
    @(posedge clk);
    #1;
    if_req = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("sf_mem_req_c%0d", c), {31'b0, mem_req}, 1);
      chk($sformatf("sf_mem_addr_c%0d", c), mem_addr, 32'h100);
      chk($sformatf("sf_mem_we_c%0d", c), {31'b0, mem_we}, 0);
      chk($sformatf("sf_busy_c%0d", c), {31'b0, busy}, 1);
      chk($sformatf("sf_rvalid_c%0d", c), {31'b0, if_rvalid}, 0);
    end
    @(negedge clk);
    chk("sf_rvalid_c4", {31'b0, if_rvalid}, 1);
    chk("sf_busy_c4", {31'b0, busy}, 0);
    wait_drain("single_fetch");

    // Table of single transactions
    for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("vec%0d", i));
    chk("store_wdata_in_ram", ram.exists(32'h2000) ? ram[32'h2000] : 32'h0, 32'hDEADBEEF);

    // Fetch timeout: mem_req exactly 8 cycles, then err + rvalid together
    @(negedge clk);
    lat_cfg = 0;
    if_req = 1; if_addr = 32'h104;
    wait_gnt(0, "to_fetch", got);
    if (got) push_exp(0, 32'h00000013, 1, 1);
    @(posedge clk);
    #1;
    if_req = 0;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (timeout_err) begin
        chk("to_rvalid_with_err", {31'b0, if_rvalid}, 1);
        break;
      end
      if (mem_req) cnt++;
    end
    chk("to_mem_req_cycles", cnt, 8);
    wait_drain("to_fetch");
    // Spurious ack in IDLE must do nothing
    spurious = 1;
    @(negedge clk);
    @(negedge clk);
    spurious = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("spur_busy", {31'b0, busy}, 0);
      chk("spur_mem_req", {31'b0, mem_req}, 0);
    end
    chk("spur_if_rdata", if_rdata, 32'h00000013);

    // Contention: both held, 1-cycle ack
    @(negedge clk);
    lat_cfg = 1;
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h500;
    n = 0;
    for (int t = 0; t < 60 && n < 10; t++) begin
      #1;
      if (busy) chk("ct_no_gnt_busy", {30'b0, if_gnt, d_gnt}, 0);
      if (if_gnt || d_gnt) begin
        chk($sformatf("ct_order%0d", n), {30'b0, if_gnt, d_gnt},
            exp_is_d[n] ? 32'd1 : 32'd2);
        if (d_gnt) push_exp(1, 32'h000000B0, 1, 0);
        else       push_exp(0, 32'h000000A0, 1, 0);
        n++;
      end
      if (n < 10) @(negedge clk);
    end
    chk("ct_grant_count", n, 10);
    @(posedge clk);
    #1;
    if_req = 0;
    d_req = 0;
    wait_drain("contention");

    // Reset while in WAIT_D
    @(negedge clk);
    lat_cfg = 0;
    d_req = 1; d_we = 1; d_addr = 32'h600; d_wdata = 32'hCAFEF00D;
    wait_gnt(1, "rst_mid", got);
    @(posedge clk);
    #1;
    d_req = 0;
    repeat (3) @(negedge clk);
    chk("rm_busy_before", {31'b0, busy}, 1);
    rst_n = 0;
    #1;
    chk("rm_mem_req", {31'b0, mem_req}, 0);
    chk("rm_mem_we", {31'b0, mem_we}, 0);
    chk("rm_busy", {31'b0, busy}, 0);
    chk("rm_mem_addr", mem_addr, 0);
    chk("rm_mem_wdata", mem_wdata, 0);
    chk("rm_if_rdata", if_rdata, 0);
    chk("rm_d_rdata", d_rdata, 0);
    chk("rm_pulses", {29'b0, if_rvalid, d_rvalid, timeout_err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    rv = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (d_rvalid || timeout_err) rv++;
    end
    chk("rm_no_rvalid_after", rv, 0);
    chk("rm_idle_after", {31'b0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
# rv32_mem_arbiter

Arbitrates the single unified memory port between the core's instruction-fetch path and its load/store data path, so one single-port RAM can serve both `pc_fetch`/`code_fetch` and the `data_addr_bus`/`write_data`/`read_data` traffic. The block sits between `rv32_cpu_top` and the memory.
- Only one transaction is outstanding at a time.
- Data requests have priority, and a starvation guard protects instruction fetch.
- A watchdog aborts hung memory accesses.
- The block drives a `busy` indication that the pipeline can use to stall.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: maximum number of consecutive data grants while a fetch is pending.
- `TIMEOUT`, default 255: maximum number of cycles to wait for `mem_ack`. Must be at least 1.
- `FETCH_NOP`, default `32'h00000013`: value returned on fetch timeout (`addi x0,x0,0`).

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request. Held, with `if_addr`, until `if_gnt`.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch request accepted at this edge (combinational).
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid in that cycle.
- `if_rdata` out DATA_W: fetched instruction.
- `d_req` in 1: data request. Held, with address/data/we, until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: data request accepted at this edge (combinational).
- `d_rvalid` out 1: one-cycle pulse. Marks load data valid, or store completion.
- `d_rdata` out DATA_W: load data.
- `mem_req` out 1: memory access active (registered).
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_ack` in 1: memory completes the access. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_err` out 1: one-cycle pulse on watchdog expiry.

## Operation
- **States:** IDLE, WAIT_IF, WAIT_D.
- **IDLE arbitration:**
  - If `d_req` is high and not (`if_req` and `starve_cnt == STARVE_MAX`): grant data. Go to WAIT_D.
  - Else if `if_req` is high: grant fetch. Go to WAIT_IF.
  - Else stay in IDLE.
- **Grant capture:** `if_gnt`/`d_gnt` are asserted only in IDLE, for the winner only, never both. At the granting edge the winner's addr/wdata/we are latched into the `mem_*` registers, `mem_req` is set to 1, and the watchdog counter is cleared.
  - A fetch grant always drives `mem_we = 0`.
- **starve_cnt** (saturating at STARVE_MAX):
  - Increments on a data grant while `if_req` is high.
  - Clears on a fetch grant.
  - Clears on a data grant while `if_req` is low.
- **WAIT_x:** `mem_ack` is sampled each cycle.
  - On ack: the owner's rdata register takes `mem_rdata` (loads and fetches only; stores leave `d_rdata` unchanged). The owner's rvalid pulses in the next cycle. `mem_req` drops. State returns to IDLE.
  - No ack: the watchdog increments. When the watchdog reaches TIMEOUT: `mem_req` drops, `timeout_err` pulses, and the owner's rvalid pulses.
    - Fetch timeout: `if_rdata = FETCH_NOP`.
    - Data timeout: `d_rdata = 0`.
    - State returns to IDLE.
- `mem_ack` is ignored in IDLE, which covers late acks after a timeout. The memory must not ack while `mem_req` is low.
- `mem_ack` in the same cycle the watchdog hits TIMEOUT: the ack wins and there is no error.

## Timing
- **Reset** (asynchronous, any state, including mid-transaction):
  - State returns to IDLE.
  - `mem_req`, `mem_we`, `busy`, `if_rvalid`, `d_rvalid`, `timeout_err` go to 0.
  - `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` go to 0.
  - `starve_cnt` and the watchdog go to 0.
  - An aborted transaction produces no rvalid.
- **Latency:** grant in cycle 0, then `mem_req` high from cycle 1. Ack in cycle k (k ≥ 1) gives rvalid in cycle k+1, with state back in IDLE in cycle k+1.
  - A new grant is possible in cycle k+1, so the minimum round trip is 2 cycles and back-to-back accesses take one every 2 cycles.
- **`busy`:** equals (state != IDLE). It is high from cycle 1 through cycle k.
- **Timeout:** `mem_req` high for exactly TIMEOUT cycles, then `timeout_err` and rvalid pulse together in the following cycle.
- **Simultaneous `if_req` and `d_req`:** data wins until `STARVE_MAX` consecutive data grants, then fetch wins exactly once.
- `*_gnt` never asserts outside IDLE. Held requests remain pending with no loss.

## Test plan
- **Single fetch:** `if_req=1`, `if_addr=0x100`, memory acks 3 cycles after `mem_req` rises with `0x00500093` → `if_gnt` in cycle 0, `mem_addr=0x100`/`mem_we=0` in cycles 1–3, `if_rvalid=1`/`if_rdata=0x00500093` in cycle 4, `busy` high in cycles 1–3.
- **Store then load:** store 0xDEADBEEF to 0x2000, then load from 0x2000 with a model RAM → `mem_we=1` with `mem_wdata=0xDEADBEEF`, `d_rvalid` pulse for the store, then `d_rdata=0xDEADBEEF`.
- **Contention/starvation:** `if_req` and `d_req` held high continuously, 1-cycle ack, `STARVE_MAX=4` → grant order D,D,D,D,IF,D,D,D,D,IF.
- **Timeout:** `TIMEOUT=8`, fetch with no ack → `mem_req` high 8 cycles, then `timeout_err=1`, `if_rvalid=1`, `if_rdata=0x00000013`. A later spurious ack in IDLE causes no effect.
- **Ack on expiry cycle:** ack arrives exactly on the TIMEOUT cycle with data `0x55` → `d_rdata=0x55`, no `timeout_err`.
- **Reset mid-transaction:** assert `rst_n=0` while in WAIT_D → all outputs 0 immediately, and no `d_rvalid` after release.
